fifo_stream_adapter: RTL and testbench

Read-side adapter that sits directly downstream of the synchronous FIFO. It drains the FIFO through its rd_en/data_out/empty port set and presents the words as a valid/ready stream with burst framing. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so the stream sustains one word per cycle under continuous m_ready with no loss or duplication.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_skid_buf.sv | 83 ++++++++
 rtl/fifo_stream_adapter.sv | 74 +++++++
 tb/tb_fifo_stream_adapter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

   typedef enum logic [1:0] {
      Occ0 = 2'd0,
      Occ1 = 2'd1,
      Occ2 = 2'd2
   } occ_e;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefBurstLen  = 4;

   // A one-word burst still needs a one-bit counter.
   function automatic int unsigned beat_width(input int unsigned burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer with occupancy FSM; a parity bit per entry is kept
// when FIFO_ADAPT_PARITY_EN is defined.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output occ_e                  occ,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data
`ifdef FIFO_ADAPT_PARITY_EN
   ,
   output logic                  parity
`endif
);

   occ_e                  occ_q, occ_d;
   logic                  head_q, head_d;
   logic                  wr_ptr;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
`ifdef FIFO_ADAPT_PARITY_EN
   logic                  par_q [2];
   logic                  par_d [2];
`endif

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      mem_d  = mem_q;
`ifdef FIFO_ADAPT_PARITY_EN
      par_d  = par_q;
`endif
      // Free slot follows the head; in Occ2 a push can only reuse the slot being popped.
      wr_ptr = (occ_q == Occ1) ? ~head_q : head_q;
      if (push) begin
         mem_d[wr_ptr] = push_data;
`ifdef FIFO_ADAPT_PARITY_EN
         par_d[wr_ptr] = ^push_data;
`endif
      end
      if (pop) head_d = ~head_q;
      unique case ({push, pop})
         2'b10:   occ_d = (occ_q == Occ0) ? Occ1 : Occ2;
         2'b01:   occ_d = (occ_q == Occ2) ? Occ1 : Occ0;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q  <= Occ0;
         head_q <= 1'b0;
         mem_q  <= '{default: '0};
`ifdef FIFO_ADAPT_PARITY_EN
         par_q  <= '{default: 1'b0};
`endif
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         mem_q  <= mem_d;
`ifdef FIFO_ADAPT_PARITY_EN
         par_q  <= par_d;
`endif
      end
   end

   assign occ   = occ_q;
   assign valid = (occ_q != Occ0);
   assign data  = mem_q[head_q];
`ifdef FIFO_ADAPT_PARITY_EN
   assign parity = par_q[head_q];
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (occ_q == Occ2)));

endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains a synchronous FIFO into a valid/ready stream with burst framing.
// Optional m_parity output is enabled by FIFO_ADAPT_PARITY_EN.
module fifo_stream_adapter
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned BURST_LEN  = DefBurstLen
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
`ifdef FIFO_ADAPT_PARITY_EN
   ,
   output logic                  m_parity
`endif
);

   localparam int unsigned      BeatW    = beat_width(BURST_LEN);
   localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

   occ_e             occ;
   logic             pop;
   logic             inflight_q, inflight_d;
   logic [BeatW-1:0] beat_q, beat_d;
   logic [1:0]       occ_cnt;
   logic [2:0]       credit;

   always_comb begin
      pop     = m_valid && m_ready;
      occ_cnt = (occ == Occ2) ? 2'd2 : ((occ == Occ1) ? 2'd1 : 2'd0);
      // Words held or landing after this edge; pop can only occur with occ >= 1.
      credit  = {1'b0, occ_cnt} + {2'b00, inflight_q} - {2'b00, pop};
      // No pop during reset: the FIFO is clearing on the same edge.
      rd_en   = rst_n && !empty && (credit < 3'd2);
      inflight_d = rd_en;
      beat_d  = beat_q;
      if (pop) beat_d = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
      m_last  = m_valid && (beat_q == LastBeat);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         beat_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
      end
   end

   fifo_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (inflight_q),
      .push_data(data_out),
      .pop      (pop),
      .occ      (occ),
      .valid    (m_valid),
      .data     (m_data)
`ifdef FIFO_ADAPT_PARITY_EN
      ,
      .parity   (m_parity)
`endif
   );

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Scoreboard bench for fifo_stream_adapter with a queue-based FIFO model.
// Build with FIFO_ADAPT_PARITY_EN to also check m_parity.
module tb_fifo_stream_adapter #(
   parameter int unsigned BL = 4
);
   localparam int unsigned DW = 8;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          empty   = 1'b1;
   logic [DW-1:0] data_out = '0;
   logic          m_ready = 1'b0;
   logic          rd_en, m_valid, m_last;
   logic [DW-1:0] m_data;
`ifdef FIFO_ADAPT_PARITY_EN
   logic          m_parity;
`endif

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] fq[$];
   logic [DW-1:0] wr_q[$];
   logic [DW-1:0] exp_q[$];
   int            xfer_cyc[$];
   int            cyc = 0;
   int            sb_idx = 0;
   int            last_cnt = 0;
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_d = '0;
   logic          hold_l = 1'b0;

   always #5 clk = ~clk;

   fifo_stream_adapter #(
      .DATA_WIDTH(DW),
      .BURST_LEN (BL)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .empty   (empty),
      .data_out(data_out),
      .rd_en   (rd_en),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
`ifdef FIFO_ADAPT_PARITY_EN
      ,
      .m_parity(m_parity)
`endif
   );

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endfunction

   function automatic void flag(input string name, input string got, input string req);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %s, required %s", name, got, req);
   endfunction

   // Synchronous FIFO: registered empty, read data one cycle after rd_en.
   always @(posedge clk) begin
      if (!rst_n) begin
         fq.delete();
         wr_q.delete();
         data_out <= '0;
         empty    <= 1'b1;
      end else begin
         if (rd_en) begin
            if (fq.size() == 0) flag("fifo_underflow", "rd_en on empty FIFO", "no read");
            else data_out <= fq.pop_front();
         end
         while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
         empty <= (fq.size() == 0);
      end
   end

   // Monitor: everything is stable at the negedge for the coming transfer edge.
   always @(negedge clk) begin
      logic [DW-1:0] w;
      cyc++;
      if (!rst_n) begin
         sb_idx = 0;
         hold_v = 1'b0;
      end else begin
         if (empty) chk("rd_en_while_empty", 32'(rd_en), 32'(0));
         if (hold_v) begin
            chk("hold_valid", 32'(m_valid), 32'(1));
            chk("hold_data", 32'(m_data), 32'(hold_d));
            chk("hold_last", 32'(m_last), 32'(hold_l));
         end
         if (m_valid && m_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               flag("unexpected_word", $sformatf("0x%0h", m_data), "no word");
            end else begin
               w = exp_q.pop_front();
               chk("data", 32'(m_data), 32'(w));
               chk("last", 32'(m_last), 32'((sb_idx % BL) == (BL - 1)));
`ifdef FIFO_ADAPT_PARITY_EN
               chk("parity", 32'(m_parity), 32'(^w));
`endif
               if (m_last) last_cnt++;
               sb_idx++;
            end
         end
         hold_v = m_valid && !m_ready;
         hold_d = m_data;
         hold_l = m_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [DW-1:0] w);
      wr_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_valid"}, 32'(m_valid), 32'(0));
      chk({name, "_data"}, 32'(m_data), 32'(0));
      chk({name, "_last"}, 32'(m_last), 32'(0));
      chk({name, "_rd_en"}, 32'(rd_en), 32'(0));
`ifdef FIFO_ADAPT_PARITY_EN
      chk({name, "_parity"}, 32'(m_parity), 32'(0));
`endif
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0)
         flag(name, $sformatf("%0d words pending", exp_q.size()), "0 pending");
      tick();
   endtask

   task automatic check_back_to_back(input string name, input int count);
      chk({name, "_count"}, 32'(xfer_cyc.size()), 32'(count));
      for (int i = 1; i < xfer_cyc.size(); i++)
         chk({name, "_gap"}, 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'(1));
   endtask

   initial begin
      logic [DW-1:0] t1_w [4];
      int            rd_cnt;
      int            base;
      int            n;

      t1_w = '{8'h11, 8'h22, 8'h33, 8'h44};

      // Reset state.
      repeat (3) tick();
      check_idle("reset");
      rst_n = 1'b1;
      tick();
      chk("post_reset_valid", 32'(m_valid), 32'(0));

      // Four words, consumer always ready.
      m_ready = 1'b1;
      xfer_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         put(t1_w[i]);
         tick();
      end
      drain("t1_drain", 40);
      check_back_to_back("t1", 4);

      // Six words while stalled: buffer fills to two, then streams gap-free.
      m_ready = 1'b0;
      rd_cnt  = 0;
      xfer_cyc.delete();
      for (int i = 0; i < 12; i++) begin
         if (i < 6) put(8'(8'hA0 + i));
         tick();
         if (rd_en) rd_cnt++;
      end
      chk("t2_rd_pulses", 32'(rd_cnt), 32'(2));
      chk("t2_held_valid", 32'(m_valid), 32'(1));
      chk("t2_held_data", 32'(m_data), 32'(8'hA0));
      m_ready = 1'b1;
      drain("t2_drain", 40);
      check_back_to_back("t2", 6);

      // Reset while one word is buffered and another is in flight.
      m_ready = 1'b0;
      put(8'h5A);
      tick();
      put(8'h5B);
      n = 0;
      while (!m_valid && n < 10) begin
         tick();
         n++;
      end
      if (!m_valid) flag("rst_wait_valid", "timeout", "m_valid");
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      check_idle("rst_mid");
      rst_n   = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_no_stale", 32'(m_valid), 32'(0));
      end

      // Ten words with m_ready toggling, counted from beat 0.
      base    = last_cnt;
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         put(8'(8'h30 + i));
         tick();
         m_ready = ~m_ready;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         tick();
         m_ready = ~m_ready;
         n++;
      end
      if (exp_q.size() != 0) flag("t3_drain", "words pending", "0 pending");
      tick();
      chk("t3_lasts", 32'(last_cnt - base), 32'(10 / BL));
      m_ready = 1'b1;
      put(8'h3A);
      tick();
      put(8'h3B);
      drain("t3_tail_drain", 40);
      chk("t3_tail_lasts", 32'(last_cnt - base), 32'(12 / BL));

      // Parity-relevant pair, then randomized traffic.
      put(8'h07);
      tick();
      put(8'h03);
      drain("par_drain", 40);
      for (int i = 0; i < 400; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) put(8'($urandom));
         tick();
      end
      m_ready = 1'b1;
      drain("rand_drain", 400);
      chk("final_pending", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit reached, required end of test");
      $fatal(1);
   end

endmodule
